// File: rtl/shift_pkg.sv
// Shared types and constants for the serial capture datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shift_pkg;

   // Receive FSM states; PARITY is only reachable when SHIFT_DESER_PARITY_EN is defined
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam logic DIR_MSB = 1'b0;
   localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/shift_out_buf.sv
// One-entry holding register for completed words: q/q_valid/par_err plus sticky overrun.
// Latency: a word offered at edge N is visible on q after edge N.
// Backpressure: a word offered while q is held and not being taken is dropped and flags overrun.
module shift_out_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             word_vld,
   input  logic [WIDTH-1:0] word_dat,
   input  logic             word_perr,
   input  logic             q_ready,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             par_err,
   output logic             overrun
);

   logic can_load;

   // The slot is free if empty, or if its current word leaves this very cycle
   assign can_load = !q_valid || q_ready;

   // Holding register: load on delivery, empty on consume; q keeps its last value when emptied
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q       <= '0;
         q_valid <= 1'b0;
         par_err <= 1'b0;
      end else if (word_vld && can_load) begin
         q       <= word_dat;
         q_valid <= 1'b1;
         par_err <= word_perr;
      end else if (q_valid && q_ready) begin
         q_valid <= 1'b0;
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else if (word_vld && !can_load) begin
         overrun <= 1'b1;
      end else if (clr_ovr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_deser.sv
// Serial-in/parallel-out receiver: one bit per cycle into WIDTH-bit words, per-word bit order, sync realign.
// Latency: q/q_valid update on the edge that samples the last bit (the parity bit with SHIFT_DESER_PARITY_EN).
// Backpressure: none on the serial side; words completing while the output slot is held are dropped (overrun).
module shift_deser
   import shift_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sync,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun,
   input  logic             clr_ovr,
   output logic             par_err
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH-1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             dir_q, dir_nxt;
   logic [WIDTH-1:0] shift_cont;
   logic [WIDTH-1:0] shift_new;
   logic             start;
   logic             word_vld;
   logic [WIDTH-1:0] word_dat;
   logic             word_perr;
`ifdef SHIFT_DESER_PARITY_EN
   logic             par_acc, par_nxt;
`endif

   // Continuing a word uses the latched order; a new word uses the live dir and starts from a clean register
   assign shift_cont = (dir_q == DIR_LSB) ? {sin, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], sin};
   assign shift_new  = (dir == DIR_MSB)   ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};

   // Receive state and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         dir_q   <= DIR_MSB;
`ifdef SHIFT_DESER_PARITY_EN
         par_acc <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= cnt_nxt;
         dir_q   <= dir_nxt;
`ifdef SHIFT_DESER_PARITY_EN
         par_acc <= par_nxt;
`endif
      end
   end

   // Next-state, shift and word-completion decode; everything holds while sin_valid is low
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = bit_cnt;
      dir_nxt   = dir_q;
      start     = 1'b0;
      word_vld  = 1'b0;
      word_dat  = shreg;
      word_perr = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      par_nxt   = par_acc;
`endif
      if (sin_valid) begin
         case (state)
            IDLE: begin
               start = 1'b1;
            end
            SHIFT: begin
               if (sync) begin
                  start = 1'b1;
               end else begin
                  shreg_nxt = shift_cont;
`ifdef SHIFT_DESER_PARITY_EN
                  par_nxt   = par_acc ^ sin;
`endif
                  if (bit_cnt == LAST_BIT) begin
                     cnt_nxt = '0;
`ifdef SHIFT_DESER_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = IDLE;
                     word_vld  = 1'b1;
                     word_dat  = shift_cont;
`endif
                  end else begin
                     cnt_nxt = bit_cnt + CNT_W'(1);
                  end
               end
            end
`ifdef SHIFT_DESER_PARITY_EN
            PARITY: begin
               if (sync) begin
                  start = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  word_vld  = 1'b1;
                  word_dat  = shreg;
                  word_perr = par_acc ^ sin;
               end
            end
`endif
            default: begin
               state_nxt = IDLE;
            end
         endcase
         if (start) begin
            state_nxt = SHIFT;
            shreg_nxt = shift_new;
            cnt_nxt   = CNT_W'(1);
            dir_nxt   = dir;
`ifdef SHIFT_DESER_PARITY_EN
            par_nxt   = sin;
`endif
         end
      end
   end

   shift_out_buf #(
      .WIDTH (WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .word_vld  (word_vld),
      .word_dat  (word_dat),
      .word_perr (word_perr),
      .q_ready   (q_ready),
      .clr_ovr   (clr_ovr),
      .q         (q),
      .q_valid   (q_valid),
      .par_err   (par_err),
      .overrun   (overrun)
   );

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-in, parallel-out receiver that is the capture end of the team's shift-register datapath: it accepts one bit per cycle from a serial stream and reassembles WIDTH-bit words for the parallel side. The bit order is selectable per word, and a sync input re-aligns framing. Completed words are presented through a one-entry valid/ready output buffer, so reception continues while the consumer stalls.

## Interface
- WIDTH, 4, data word width (≥2)
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, do not override)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- sin  in  1  serial data bit
- sin_valid  in  1  sin holds a valid bit this cycle
- sync  in  1  qualified by sin_valid: this bit is bit 0 of a new word
- dir  in  1  0 = MSB first, 1 = LSB first; sampled with bit 0 of each word
- q  out  WIDTH  received word
- q_valid  out  1  q holds an unconsumed word
- q_ready  in  1  consumer accepts q when q_valid && q_ready
- bit_cnt  out  CNT_W  data bits received in current partial word
- overrun  out  1  sticky: a completed word was dropped
- clr_ovr  in  1  synchronous clear of overrun
- par_err  out  1  parity error for the word in q, valid with q_valid

## Operation
- States: IDLE (no partial word), SHIFT (bit_cnt 1..WIDTH-1), PARITY (only with macro).
- sin_valid low: all receive state holds.
- A bit accepted in IDLE starts a word, latches dir, and moves to SHIFT; sync is irrelevant in IDLE.
- dir=0: shreg <= {shreg[WIDTH-2:0], sin}. dir=1: shreg <= {sin, shreg[WIDTH-1:1]}.
- WIDTH-th bit: word complete. Without macro, go to IDLE and deliver; with macro, go to PARITY.
- sync && sin_valid in SHIFT/PARITY: discard the partial word (no delivery, no overrun), treat the bit as bit 0 of a new word, relatch dir.
- Delivery: if !q_valid, or q_valid && q_ready in the same cycle, load q and set q_valid=1. Otherwise drop the new word, keep the old q, and set overrun.
- q_valid && q_ready with no delivery: q_valid <= 0. q retains its last value.
- overrun: clr_ovr clears it. If a set and a clear land in the same cycle, set wins.

## Timing
- Reset values: q=0, q_valid=0, bit_cnt=0, overrun=0, par_err=0, state IDLE, shreg=0.
- Reset mid-word: the partial word is lost immediately and asynchronously.
- Latency: the last bit is sampled at edge N and q/q_valid are visible after edge N. With the macro, the parity bit's edge is the delivery edge.
- bit_cnt increments on every accepted data bit and returns to 0 on completion (1 on a sync bit).
- Back-to-back words at full rate with q_ready tied high: no gaps, no overrun.

## Configuration
- SHIFT_DESER_PARITY_EN defined: one parity bit follows each WIDTH-bit word (PARITY state). Even parity covers data and parity bit. par_err = XOR of all WIDTH+1 bits, registered with q. An overrun-dropped word drops its par_err too.
- Not defined: no PARITY state and par_err is tied 0. The port list is unchanged.

## Structure
- Package shift_pkg: state enum typedef (IDLE, SHIFT, PARITY), constants DIR_MSB=1'b0 and DIR_LSB=1'b1.
- Sub-module shift_out_buf: one-entry q/q_valid/par_err holding register with handshake and overrun logic. The top level contains the FSM, shreg and bit_cnt.

## Test plan
- Reset with rst=0, then release; dir=0, bits 1,0,1,0 on consecutive cycles -> q=4'b1010, q_valid=1 after 4th edge, bit_cnt=0.
- dir=1, bits 0,1,0,1 -> q=4'b1010; then q_ready=1 for one cycle -> q_valid=0.
- q_ready=0; send 4'b1010 then 4'b0110 -> q stays 4'b1010, overrun=1; clr_ovr pulse -> overrun=0.
- Bits 1,1 then sync with bits 0,0,1,1 -> only q=4'b0011 delivered, overrun=0.
- rst asserted after 2 bits -> bit_cnt=0, q_valid=0 at once; a fresh 4-bit word then arrives correctly.
- With SHIFT_DESER_PARITY_EN: 1,0,1,0 + parity 0 -> par_err=0; 1,0,1,1 + parity 0 -> par_err=1.
